// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-read/two-write register file with per-register busy scoreboard
// Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle writes to the read ports.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            rb1,
    output logic            rb2,
    input  logic            we0,
    input  logic            we1,
    input  logic [AW-1:0]   wa0,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd0,
    input  logic [XLEN-1:0] wd1,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;

    // A reserve in the same cycle as a write wins: it names the newer producer.
    always_comb begin
        busy_d = busy_q;
        if (we0) busy_d[wa0] = 1'b0;
        if (we1) busy_d[wa1] = 1'b0;
        if (rsv_en) busy_d[rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
        if (cnt_d > (AW+1)'(NREG - 1)) begin
            cnt_d = (AW+1)'(NREG - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (we0 && wa0 != '0) regs_q[wa0] <= wd0;
            if (we1 && wa1 != '0) regs_q[wa1] <= wd1;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

`ifdef REGFILE_SB_BYPASS_EN
    logic hit0_1, hit1_1, hit0_2, hit1_2;
    logic rsv_1, rsv_2;

    assign hit0_1 = we0 && (wa0 == ra1) && (ra1 != '0);
    assign hit1_1 = we1 && (wa1 == ra1) && (ra1 != '0);
    assign hit0_2 = we0 && (wa0 == ra2) && (ra2 != '0);
    assign hit1_2 = we1 && (wa1 == ra2) && (ra2 != '0);
    assign rsv_1  = rsv_en && (rsv_addr == ra1);
    assign rsv_2  = rsv_en && (rsv_addr == ra2);

    always_comb begin
        rd1 = hit1_1 ? wd1 : (hit0_1 ? wd0 : regs_q[ra1]);
        rd2 = hit1_2 ? wd1 : (hit0_2 ? wd0 : regs_q[ra2]);
        rb1 = (hit0_1 || hit1_1) ? rsv_1 : busy_q[ra1];
        rb2 = (hit0_2 || hit1_2) ? rsv_2 : busy_q[ra2];
    end
`else
    assign rd1 = regs_q[ra1];
    assign rd2 = regs_q[ra2];
    assign rb1 = busy_q[ra1];
    assign rb2 = busy_q[ra2];
`endif

endmodule
